// File: rtl/ising_energy_engine.sv
// Streaming sigma^T J sigma evaluator: J arrives column-chunk by column-chunk,
// each column is reduced against sigma, then signed by its own spin and accumulated.

module ising_col_dot #(
  parameter int VS = 8,
  parameter int JW = 4,
  parameter int EW = 12,
  parameter int J_SIGNED = 0
) (
  input  logic [VS-1:0]          sigma,
  input  logic [VS-1:0][JW-1:0]  col,
  output logic signed [EW-1:0]   dot
);
  logic signed [EW-1:0] ext;

  always_comb begin
    dot = '0;
    ext = '0;
    for (int r = 0; r < VS; r++) begin
      ext = (J_SIGNED != 0) ? {{(EW-JW){col[r][JW-1]}}, col[r]} : {{(EW-JW){1'b0}}, col[r]};
      dot = sigma[r] ? dot + ext : dot - ext;
    end
  end
endmodule

module ising_energy_engine #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int COLS_PER_CLK    = 4,
  parameter int J_SIGNED        = 0,
  parameter int PIPELINE        = 1,
  localparam int NUM_CHUNKS   = VECTOR_SIZE / COLS_PER_CLK,
  localparam int ENERGY_WIDTH = 2*$clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 2,
  localparam int IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
  localparam int SIG_W        = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic                                            abort,
  input  logic [VECTOR_SIZE-1:0]                          sigma,
  input  logic signed [ENERGY_WIDTH-1:0]                  energy_prev,
  input  logic                                            j_valid,
  output logic                                            j_ready,
  input  logic [VECTOR_SIZE*COLS_PER_CLK*J_ELEMENT_WIDTH-1:0] j_chunk,
  output logic [IDX_W-1:0]                                j_chunk_idx,
  output logic                                            busy,
  output logic                                            done,
  output logic signed [ENERGY_WIDTH-1:0]                  energy_out,
  output logic                                            exceeded
);
  localparam int EW = ENERGY_WIDTH;
  localparam int JW = J_ELEMENT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [VECTOR_SIZE-1:0]  sigma_q;
  logic signed [EW-1:0]    ep_q, acc, acc_nxt, blk, add_term;
  logic                    accept, last;
  logic [SIG_W-1:0]        gcol;

  logic [COLS_PER_CLK-1:0][VECTOR_SIZE-1:0][JW-1:0] cols;
  logic signed [EW-1:0] dots [COLS_PER_CLK];

  genvar c, r;
  generate
    for (c = 0; c < COLS_PER_CLK; c++) begin : g_col
      for (r = 0; r < VECTOR_SIZE; r++) begin : g_row
        assign cols[c][r] = j_chunk[(r*COLS_PER_CLK+c)*JW +: JW];
      end
      ising_col_dot #(.VS(VECTOR_SIZE), .JW(JW), .EW(EW), .J_SIGNED(J_SIGNED)) u_dot (
        .sigma (sigma_q),
        .col   (cols[c]),
        .dot   (dots[c])
      );
    end
  endgenerate

  assign last   = (j_chunk_idx == IDX_W'(NUM_CHUNKS-1));
  assign accept = j_valid && j_ready && !abort;

  // Each column's dot product is weighted by the spin of that global column.
  always_comb begin
    blk  = '0;
    gcol = '0;
    for (int i = 0; i < COLS_PER_CLK; i++) begin
      gcol = SIG_W'(32'(j_chunk_idx) * COLS_PER_CLK + i);
      blk  = sigma_q[gcol] ? blk + dots[i] : blk - dots[i];
    end
  end

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic signed [EW-1:0] blk_q;
      logic                 blk_vld;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          blk_q   <= '0;
          blk_vld <= 1'b0;
        end else if (state == IDLE || abort) begin
          blk_q   <= '0;
          blk_vld <= 1'b0;
        end else begin
          blk_q   <= blk;
          blk_vld <= accept;
        end
      end
      assign add_term = blk_vld ? blk_q : '0;
    end else begin : g_comb
      assign add_term = accept ? blk : '0;
    end
  endgenerate

  assign acc_nxt = acc + add_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    j_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        j_ready = 1'b1;
        busy    = 1'b1;
        if (abort)              state_nxt = IDLE;
        else if (accept && last) state_nxt = (PIPELINE != 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sigma_q     <= '0;
      ep_q        <= '0;
      acc         <= '0;
      j_chunk_idx <= '0;
      energy_out  <= '0;
      exceeded    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        sigma_q     <= sigma;
        ep_q        <= energy_prev;
        acc         <= '0;
        j_chunk_idx <= '0;
        energy_out  <= '0;
        exceeded    <= 1'b0;
      end
    end else if (abort) begin
      acc         <= '0;
      j_chunk_idx <= '0;
    end else begin
      acc <= acc_nxt;
      if (accept) j_chunk_idx <= last ? '0 : j_chunk_idx + 1'b1;
      // Results only move when the final sum is known, so aborts leave them at 0.
      if (state_nxt == DONE) begin
        energy_out <= acc_nxt;
        exceeded   <= (acc_nxt >= ep_q);
      end
    end
  end
endmodule
